// File: rtl/operand_ram.sv
// Banked operand store with a streaming load port, a random-access read/write port,
// and a clear sequencer that zeroes every word after reset or on request.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle, all ports ignored, busy high
// ST_IDLE  | load, random-access write and read ports active
module operand_ram #(
   parameter  int WIDTH     = 32,
   parameter  int DEPTH     = 8,
   parameter  int BANKS     = 2,
   parameter  int READ_MODE = 0,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr_req,
   output logic             o_busy,
   input  logic             i_ld_valid,
   output logic             o_ld_ready,
   input  logic [BW-1:0]    i_ld_bank,
   input  logic [WIDTH-1:0] i_ld_data,
   output logic             o_ld_done,
   input  logic             i_wr_en,
   input  logic             i_rd_en,
   input  logic [BW-1:0]    i_bank,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid
);

   localparam int N  = BANKS * DEPTH;
   localparam int NW = (N > 1) ? $clog2(N) : 1;

   localparam logic ST_CLEAR = 1'b0;
   localparam logic ST_IDLE  = 1'b1;

   logic             r_state;
   logic [NW-1:0]    r_clr_cnt;
   logic [AW-1:0]    r_ld_cnt;
   logic [BW-1:0]    r_ld_bank;
   logic             r_ld_done;
   logic [WIDTH-1:0] r_rd_data;
   logic             r_rd_valid;
   logic [WIDTH-1:0] r_mem [N];

   logic             w_idle;
   logic             w_ld_acc;
   logic [BW-1:0]    w_ld_bank;
   logic             w_ld_ok;
   logic             w_ra_ok;
   logic [NW-1:0]    w_ld_idx;
   logic [NW-1:0]    w_ra_idx;
   logic             w_we;
   logic [NW-1:0]    w_widx;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_rd_word;

   assign w_idle     = (r_state == ST_IDLE);
   assign o_busy     = !w_idle;
   assign o_ld_ready = w_idle && !i_wr_en && !i_clr_req;
   assign w_ld_acc   = i_ld_valid && o_ld_ready;
   assign o_ld_done  = r_ld_done;
   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

   // The bank for beat 0 comes straight from the port; later beats use the captured copy.
   assign w_ld_bank = (r_ld_cnt == '0) ? i_ld_bank : r_ld_bank;
   assign w_ld_ok   = ({1'b0, w_ld_bank} < (BW+1)'(BANKS));
   assign w_ra_ok   = ({1'b0, i_bank} < (BW+1)'(BANKS)) && ({1'b0, i_addr} < (AW+1)'(DEPTH));
   assign w_ld_idx  = NW'(w_ld_bank) * NW'(DEPTH) + NW'(r_ld_cnt);
   assign w_ra_idx  = NW'(i_bank) * NW'(DEPTH) + NW'(i_addr);

   // Single write port: clear, then random-access write, then load beat.
   always_comb begin
      w_we    = 1'b0;
      w_widx  = '0;
      w_wdata = '0;
      if (!w_idle) begin
         w_we   = 1'b1;
         w_widx = r_clr_cnt;
      end else if (i_wr_en) begin
         w_we    = w_ra_ok;
         w_widx  = w_ra_idx;
         w_wdata = i_wr_data;
      end else if (w_ld_acc) begin
         w_we    = w_ld_ok;
         w_widx  = w_ld_idx;
         w_wdata = i_ld_data;
      end
   end

   always_comb begin
      w_rd_word = '0;
      if (w_ra_ok) begin
         w_rd_word = r_mem[w_ra_idx];
         if (READ_MODE == 1 && w_we && (w_widx == w_ra_idx)) begin
            w_rd_word = w_wdata;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_mem[w_widx] <= w_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_CLEAR;
         r_clr_cnt  <= '0;
         r_ld_cnt   <= '0;
         r_ld_bank  <= '0;
         r_ld_done  <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_ld_done  <= 1'b0;
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
               if (r_clr_cnt == NW'(N - 1)) begin
                  r_state   <= ST_IDLE;
                  r_clr_cnt <= '0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
            default: begin
               if (i_clr_req) begin
                  r_state  <= ST_CLEAR;
                  r_ld_cnt <= '0;
               end else if (w_ld_acc) begin
                  if (r_ld_cnt == '0) begin
                     r_ld_bank <= i_ld_bank;
                  end
                  if (r_ld_cnt == AW'(DEPTH - 1)) begin
                     r_ld_cnt  <= '0;
                     r_ld_done <= 1'b1;
                  end else begin
                     r_ld_cnt <= r_ld_cnt + 1'b1;
                  end
               end
               if (i_rd_en) begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= w_rd_word;
               end
            end
         endcase
      end
   end

endmodule
